rx4p_sync_fifo: RTL and testbench
=================================

Name: rx4p_sync_fifo

Overview:
- Parametrised successor to the two-flop 4-phase receiver.
- Receives words from a foreign clock domain over a 4-phase req/ack handshake, using a req synchroniser of configurable depth.
- Buffers received words in a show-ahead FIFO that drains to the local core over a valid/ready interface.
- Holds ack low while the FIFO is full, which back-pressures the sender without losing data.

Parameters:
DATA_WIDTH, 8, width of input_rx and out_data
SYNC_STAGES, 2, flops in the req synchroniser (legal range 2..4)
FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, at least 2
ADDR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived; do not override)

Ports:
clk  input  1  single clock; every flop is clocked on its rising edge
reset  input  1  asynchronous, active-low; 0 resets all state, release is synchronous to clk
req  input  1  4-phase request from the sender (asynchronous to clk)
input_rx  input  DATA_WIDTH  sender data; stable while req=1
ack  output  1  4-phase acknowledge to the sender (registered)
d  output  1  one-cycle pulse when a word is captured
out_data  output  DATA_WIDTH  FIFO head word
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer pop request
fill_level  output  ADDR_W+1  number of FIFO entries in use
proto_err  output  1  sticky flag: req dropped before ack was given

Behaviour:
- Reset (reset=0, asynchronous):
  - ack=0, d=0, out_valid=0, fill_level=0, proto_err=0.
  - Synchroniser flops=0; FSM goes to IDLE; read and write pointers=0.
  - out_data is don't-care while out_valid=0.
- Synchroniser:
  - req passes through SYNC_STAGES flops; the last stage is req_s.
  - Only req_s is used internally.
- FSM, states IDLE and ACKED:
  - IDLE, req_s=1, !full: write input_rx to the FIFO, set d=1 for one cycle, set ack=1 (registered, same edge), go to ACKED.
  - IDLE, req_s=1, full: stall with ack=0 and no write. Re-check every cycle; capture on the first cycle the FIFO is not full.
  - ACKED: hold ack=1. When req_s=0, clear ack on the next edge and return to IDLE.
  - A second word cannot be captured until req has gone low and then high again (full 4-phase return to zero).
- Stall and protocol error:
  - A word is "pending" when req_s was 1 in IDLE and the previous cycle stalled on full.
  - If req_s then falls while still in IDLE, set proto_err=1. It stays set until reset.
  - No write occurs in that case.
- Latency:
  - req rise to ack rise is SYNC_STAGES+1 clk edges when the FIFO is not full.
  - req fall to ack fall is SYNC_STAGES+1 edges.
- FIFO:
  - Pointers are ADDR_W+1 bits with a wrap bit.
  - full when the pointers differ only in the MSB; empty when they are equal.
  - out_data = mem[rd_ptr] (show-ahead, no read latency); out_valid = !empty.
  - Pop when out_valid & out_ready; popping while empty has no effect.
  - full is evaluated from the registered pointers. A pop in the same cycle does not unblock a write; capture happens the following cycle.
  - Push and pop in the same cycle (not full, not empty): fill_level is unchanged and both pointers advance.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- Reset mid-transfer: ack falls immediately (asynchronously) and buffered data is discarded. The sender must restart its handshake from req=0.

Optional Feature:
RX_PARITY_EN
- Defined:
  - Adds input port input_par (1 bit) and output port par_err (1 bit, resets to 0).
  - On each capture, even parity of {input_rx, input_par} is checked; a mismatch sets par_err sticky until reset.
  - The word is still stored and acknowledged.
- Undefined: both ports are absent; behaviour is otherwise identical.

Test Plan:
- Single transfer: SYNC_STAGES=2, input_rx=8'hA5, req 0→1:
  - ack rises 3 edges later; d pulses once; out_valid=1; out_data=8'hA5; fill_level=1.
  - Drop req: ack falls 3 edges later.
- Fill with back-pressure, FIFO_DEPTH=4, out_ready=0:
  - Send 8'h01..8'h05; the first 4 are acked and fill_level=4.
  - On the 5th, ack stays 0 and d stays 0.
  - Raise out_ready for one cycle: pop 8'h01; 8'h05 is captured one cycle later and ack rises.
  - Drain order 02,03,04,05.
- Simultaneous push/pop at fill_level=2 with out_ready=1: fill_level stays 2; output order is preserved across the pointer wrap.
- Protocol error: FIFO full, req=1 stalled, then req dropped before any ack → proto_err=1, no write, fill_level unchanged.
- Async reset during ACKED with fill_level=3: ack=0 and out_valid=0 immediately. After release, a new transfer of 8'h3C works normally.
- With RX_PARITY_EN: input_rx=8'h03, input_par=1 → par_err=1, word stored. With input_par=0 on a fresh reset → par_err stays 0.

Source files
------------

// File: rtl/rx4p_sync_fifo.sv
// 4-phase req/ack receiver with a configurable req synchroniser and show-ahead FIFO.
// Optional RX_PARITY_EN adds input_par/par_err even-parity checking on capture.
module rx4p_sync_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] input_rx,
`ifdef RX_PARITY_EN
    input  logic                  input_par,
    output logic                  par_err,
`endif
    output logic                  ack,
    output logic                  d,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W:0]       fill_level,
    output logic                  proto_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    req_s;
    logic                    ack_nxt;
    logic                    capture;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic                    stall_q;
    logic [ADDR_W:0]         wr_ptr;
    logic [ADDR_W:0]         rd_ptr;
    logic [ADDR_W:0]         ptr_diff;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign ptr_diff = wr_ptr ^ rd_ptr;
    assign full     = (ptr_diff == {1'b1, {ADDR_W{1'b0}}});
    assign empty    = (wr_ptr == rd_ptr);
    assign pop      = !empty && out_ready;

    assign out_valid  = !empty;
    assign out_data   = mem[rd_ptr[ADDR_W-1:0]];
    assign fill_level = wr_ptr - rd_ptr;

    // Shift the foreign req through the synchroniser chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], req};
    end

    // Handshake state, registered ack and one-cycle capture strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ack   <= 1'b0;
            d     <= 1'b0;
        end else begin
            state <= state_nxt;
            ack   <= ack_nxt;
            d     <= capture;
        end
    end

    // Capture only from IDLE with room; ACKED waits for req return to zero.
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_s && !full) begin
                    capture   = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = ACKED;
                end
            end
            ACKED: begin
                if (req_s) ack_nxt   = 1'b1;
                else       state_nxt = IDLE;
            end
        endcase
    end

    // A stalled request that is withdrawn before ack is a sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            stall_q <= (state == IDLE) && req_s && full;
            if ((state == IDLE) && !req_s && stall_q)
                proto_err <= 1'b1;
        end
    end

    // Write and read pointers carry a wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; pointer reset discards its contents.
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr[ADDR_W-1:0]] <= input_rx;
    end

`ifdef RX_PARITY_EN
    // Word plus parity bit must hold an even number of ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          par_err <= 1'b0;
        else if (capture && ^{input_rx, input_par}) par_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_rx4p_sync_fifo.sv
// Directed bench for rx4p_sync_fifo (default parameters).
// Parity cases run only when RX_PARITY_EN is defined.
module tb_rx4p_sync_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [7:0] input_rx;
    logic       ack;
    logic       d;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fill_level;
    logic       proto_err;
`ifdef RX_PARITY_EN
    logic       input_par;
    logic       par_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rx4p_sync_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .input_rx   (input_rx),
`ifdef RX_PARITY_EN
        .input_par  (input_par),
        .par_err    (par_err),
`endif
        .ack        (ack),
        .d          (d),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level),
        .proto_err  (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (ack == lvl) break;
            tick();
        end
        chk(tag, ack, lvl);
    endtask

    task automatic send(input logic [7:0] v);
        input_rx = v;
        req      = 1'b1;
        wait_ack(1'b1, "send ack rise");
        req = 1'b0;
        wait_ack(1'b0, "send ack fall");
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] v, input logic [7:0] head);
        input_rx = v;
        req      = 1'b1;
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp ack", ack, 1'b1);
        chk("pp fill", fill_level, 3'd2);
        chk("pp head", out_data, head);
        req = 1'b0;
        wait_ack(1'b0, "pp ack fall");
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        req   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    logic       seen_d;
    logic       seen_ack;
    logic [7:0] drain_exp [4];

    initial begin
        reset     = 1'b0;
        req       = 1'b0;
        input_rx  = '0;
        out_ready = 1'b0;
`ifdef RX_PARITY_EN
        input_par = 1'b0;
`endif
        tick();
        tick();
        chk("rst ack", ack, 1'b0);
        chk("rst d", d, 1'b0);
        chk("rst valid", out_valid, 1'b0);
        chk("rst fill", fill_level, 3'd0);
        chk("rst perr", proto_err, 1'b0);
        reset = 1'b1;
        tick();

        // single transfer, cycle exact
        input_rx = 8'hA5;
        req      = 1'b1;
        tick();
        chk("st ack e1", ack, 1'b0);
        tick();
        chk("st ack e2", ack, 1'b0);
        tick();
        chk("st ack e3", ack, 1'b1);
        chk("st d", d, 1'b1);
        chk("st valid", out_valid, 1'b1);
        chk("st data", out_data, 8'hA5);
        chk("st fill", fill_level, 3'd1);
        tick();
        chk("st d low", d, 1'b0);
        req = 1'b0;
        tick();
        tick();
        chk("st ack hold", ack, 1'b1);
        tick();
        chk("st ack fall", ack, 1'b0);
        pop_one();
        chk("st pop fill", fill_level, 3'd0);
        chk("st pop valid", out_valid, 1'b0);

        // fill with back-pressure
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        chk("fill full", fill_level, 3'd4);
        input_rx = 8'h05;
        req      = 1'b1;
        seen_d   = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_d   = seen_d | d;
            seen_ack = seen_ack | ack;
        end
        chk("stall ack", seen_ack, 1'b0);
        chk("stall d", seen_d, 1'b0);
        chk("stall fill", fill_level, 3'd4);
        chk("stall head", out_data, 8'h01);
        pop_one();
        chk("unblk ack0", ack, 1'b0);
        chk("unblk head", out_data, 8'h02);
        chk("unblk fill3", fill_level, 3'd3);
        tick();
        chk("unblk ack1", ack, 1'b1);
        chk("unblk d", d, 1'b1);
        chk("unblk fill4", fill_level, 3'd4);
        req = 1'b0;
        wait_ack(1'b0, "unblk ack fall");
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < 4; i++) begin
            chk("drain data", out_data, drain_exp[i]);
            pop_one();
        end
        chk("drain empty", out_valid, 1'b0);

        // simultaneous push/pop across pointer wrap
        send(8'h10);
        send(8'h11);
        chk("pp start", fill_level, 3'd2);
        push_pop(8'h12, 8'h11);
        push_pop(8'h13, 8'h12);
        push_pop(8'h14, 8'h13);
        chk("pp tail a", out_data, 8'h13);
        pop_one();
        chk("pp tail b", out_data, 8'h14);
        pop_one();
        chk("pp empty", out_valid, 1'b0);

        // protocol error: req withdrawn while stalled
        send(8'h20);
        send(8'h21);
        send(8'h22);
        send(8'h23);
        input_rx = 8'h77;
        req      = 1'b1;
        repeat (5) tick();
        chk("pe before", proto_err, 1'b0);
        req = 1'b0;
        repeat (5) tick();
        chk("pe flag", proto_err, 1'b1);
        chk("pe fill", fill_level, 3'd4);
        chk("pe ack", ack, 1'b0);
        chk("pe head", out_data, 8'h20);

        // async reset in ACKED with three words held
        pop_one();
        pop_one();
        input_rx = 8'h55;
        req      = 1'b1;
        wait_ack(1'b1, "ar ack rise");
        chk("ar fill", fill_level, 3'd3);
        #2;
        reset = 1'b0;
        req   = 1'b0;
        #1;
        chk("ar ack", ack, 1'b0);
        chk("ar valid", out_valid, 1'b0);
        chk("ar fill0", fill_level, 3'd0);
        chk("ar perr", proto_err, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        send(8'h3C);
        chk("ar new data", out_data, 8'h3C);
        chk("ar new fill", fill_level, 3'd1);

`ifdef RX_PARITY_EN
        do_reset();
        input_par = 1'b1;
        send(8'h03);
        chk("par err set", par_err, 1'b1);
        chk("par data", out_data, 8'h03);
        chk("par fill", fill_level, 3'd1);
        do_reset();
        input_par = 1'b0;
        send(8'h03);
        chk("par err clr", par_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
